// File: rtl/riscv_divider.sv
// riscv_divider
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Each operation runs a restoring division on operand magnitudes, one
// quotient bit per unheld cycle over 32 cycles. The sign is fixed up
// when the last bit is produced. Divide-by-zero and signed overflow
// skip the iteration and complete one cycle after accept.

module riscv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [31:0]     opcode,
    input  logic [4:0]      rd_idx,
    input  logic [XLEN-1:0] ra_operand,
    input  logic [XLEN-1:0] rb_operand,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] wb_value,
    output logic [4:0]      wb_rd_idx
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    // Control state
    logic [1:0]      state;
    logic [4:0]      count;

    // Datapath state: partial remainder, dividend shifting out / quotient
    // shifting in, and divisor magnitude.
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] dsr_reg;
    logic            sel_rem;
    logic            neg_quo;
    logic            neg_rem;
    logic [4:0]      rd_reg;

    // Decode and accept signals
    logic            div_inst;
    logic            op_unsigned;
    logic            op_rem;
    logic            accept;
    logic            ra_neg;
    logic            rb_neg;
    logic [XLEN-1:0] ra_abs;
    logic [XLEN-1:0] rb_abs;
    logic            div_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] special_val;

    // Iteration signals
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] final_val;

    // Operand fields not used by the decoder.
    logic unused_opcode_bits;
    assign unused_opcode_bits = &{1'b0, opcode[24:15], opcode[11:7]};

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    // Decode the instruction and classify the operands at accept time.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        div_inst    = (opcode[6:0] == 7'b0110011) && (opcode[31:25] == 7'b0000001) && opcode[14];
        op_unsigned = opcode[12];
        op_rem      = opcode[13];
        accept      = 1'b0;
        if ((state == ST_IDLE) || (state == ST_DONE)) begin
            accept = valid && div_inst && !hold;
        end

        ra_neg = !op_unsigned && ra_operand[XLEN-1];
        rb_neg = !op_unsigned && rb_operand[XLEN-1];
        // Negating 0x80000000 wraps back to itself, which is the correct
        // magnitude when read as unsigned.
        ra_abs = ra_neg ? (~ra_operand + 1'b1) : ra_operand;
        rb_abs = rb_neg ? (~rb_operand + 1'b1) : rb_operand;

        div_zero = (rb_operand == '0);
        sgn_ovf  = !op_unsigned && (ra_operand == MIN_NEG) && (rb_operand == ALL_ONE);
        special  = div_zero || sgn_ovf;

        special_val = '0;
        if (div_zero) begin
            special_val = op_rem ? ra_operand : ALL_ONE;
        end else if (sgn_ovf) begin
            special_val = op_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step: trial-subtract the divisor from the shifted
    // remainder, keep the difference when it is non-negative.
    always_comb begin
        shifted  = {rem_reg, quo_reg[XLEN-1]};
        trial    = {1'b0, shifted} - {2'b00, dsr_reg};
        q_bit    = !trial[XLEN+1];
        // The kept remainder is always below the divisor, so it fits in XLEN bits.
        rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next = {quo_reg[XLEN-2:0], q_bit};

        if (sel_rem) begin
            final_val = neg_rem ? (~rem_next + 1'b1) : rem_next;
        end else begin
            final_val = neg_quo ? (~quo_next + 1'b1) : quo_next;
        end
    end

    // Sequence IDLE/BUSY/DONE, count iterations, register the writeback.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            wb_value  <= '0;
            wb_rd_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (special) begin
                            state     <= ST_DONE;
                            wb_value  <= special_val;
                            wb_rd_idx <= rd_idx;
                        end else begin
                            state <= ST_BUSY;
                            count <= 5'd31;
                        end
                    end else if (!hold) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!hold) begin
                        count <= count - 5'd1;
                        if (count == 5'd0) begin
                            state     <= ST_DONE;
                            wb_value  <= final_val;
                            wb_rd_idx <= rd_reg;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Load operands on a normal accept, then shift one bit per unheld BUSY cycle.
    always_ff @(posedge clk) begin
        // NOTE: the datapath has no reset; it is always loaded at accept before any value of it is used.
        if (accept && !special) begin
            rem_reg <= '0;
            quo_reg <= ra_abs;
            dsr_reg <= rb_abs;
            sel_rem <= op_rem;
            neg_quo <= ra_neg ^ rb_neg;
            neg_rem <= ra_neg;
            rd_reg  <= rd_idx;
        end else if ((state == ST_BUSY) && !hold) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
        end
    end

endmodule

// File: tb/tb_riscv_divider.sv
// tb_riscv_divider
// Directed and randomized checks of riscv_divider against an arithmetic
// reference model of the RV32M divide/remainder rules.

module tb_riscv_divider;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] opcode;
    logic [4:0]  rd_idx;
    logic [31:0] ra_operand;
    logic [31:0] rb_operand;
    logic        hold;
    logic        busy;
    logic        done;
    logic [31:0] wb_value;
    logic [4:0]  wb_rd_idx;

    int n_checks = 0;
    int n_fails  = 0;

    riscv_divider #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .opcode     (opcode),
        .rd_idx     (rd_idx),
        .ra_operand (ra_operand),
        .rb_operand (rb_operand),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .wb_value   (wb_value),
        .wb_rd_idx  (wb_rd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // sel[0] = unsigned, sel[1] = remainder (funct3 = {1, sel}).
    function automatic logic [31:0] mk_op(input logic [1:0] sel);
        return {7'b0000001, 10'd0, 1'b1, sel, 5'd0, 7'b0110011};
    endfunction

    function automatic bit is_special(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return sel[1] ? a : 32'hFFFF_FFFF;
        if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return sel[1] ? 32'd0 : 32'h8000_0000;
        if (sel[0]) return sel[1] ? (a % b) : (a / b);
        sa = $signed(a);
        sb = $signed(b);
        return sel[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Issue one op and follow it to completion. hold_len cycles of hold are
    // applied starting ten edges after accept; optionally a second valid
    // instruction is presented mid-BUSY and must be ignored.
    task automatic run_op(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold_len, input bit inject);
        int          edges;
        bit          spec;
        logic [31:0] exp_val;
        spec    = is_special(sel, a, b);
        exp_val = ref_result(sel, a, b);

        @(negedge clk);
        valid      = 1'b1;
        opcode     = mk_op(sel);
        rd_idx     = rd;
        ra_operand = a;
        rb_operand = b;
        hold       = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            hold = (hold_len > 0) && (edges >= 10) && (edges < 10 + hold_len);
            if (inject && edges == 20) begin
                valid      = 1'b1;
                opcode     = mk_op(2'b01);
                rd_idx     = 5'd31;
                ra_operand = 32'd50;
                rb_operand = 32'd5;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        hold  = 1'b0;
        valid = 1'b0;
        check({tag, "_latency"}, edges, spec ? 32'd0 : 32'(32 + hold_len));
        check({tag, "_excl"}, {31'd0, busy}, 32'd0);
        check({tag, "_value"}, wb_value, exp_val);
        check({tag, "_rd"}, {27'd0, wb_rd_idx}, {27'd0, rd});
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_keep"}, wb_value, exp_val);
    endtask

    initial begin
        int late;
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;

        // Reset together with a valid DIVU: reset wins.
        rst_n      = 1'b0;
        hold       = 1'b0;
        valid      = 1'b1;
        opcode     = mk_op(2'b01);
        rd_idx     = 5'd3;
        ra_operand = 32'd100;
        rb_operand = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wb", wb_value, 32'd0);
        check("rst_rd", {27'd0, wb_rd_idx}, 32'd0);
        valid = 1'b0;
        rst_n = 1'b1;

        // Valid with hold in IDLE, and a non-divide opcode: neither accepted.
        @(negedge clk);
        valid = 1'b1;
        hold  = 1'b1;
        @(posedge clk);
        #1;
        check("hold_idle_busy", {31'd0, busy | done}, 32'd0);
        hold   = 1'b0;
        opcode = 32'h0220_80B3; // MUL
        @(posedge clk);
        #1;
        check("mul_ignored", {31'd0, busy | done}, 32'd0);
        valid = 1'b0;

        run_op("divu_100_7", 2'b01, 5'd5, 32'd100, 32'd7, 0, 1'b0);
        run_op("remu_100_7", 2'b11, 5'd5, 32'd100, 32'd7, 0, 1'b0);
        run_op("div_m7_2",   2'b00, 5'd9, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op("rem_m7_2",   2'b10, 5'd9, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op("rem_7_m2",   2'b10, 5'd1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        run_op("div_ovf",    2'b00, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("rem_ovf",    2'b10, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("divu_zero",  2'b01, 5'd4, 32'h0000_1234, 32'd0, 0, 1'b0);
        run_op("rem_zero",   2'b10, 5'd6, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
        run_op("divu_hold",  2'b01, 5'd8, 32'hFFFF_FFFF, 32'd3, 5, 1'b1);

        // Reset in the middle of an operation.
        @(negedge clk);
        valid      = 1'b1;
        opcode     = mk_op(2'b01);
        rd_idx     = 5'd7;
        ra_operand = 32'hFFFF_FFFF;
        rb_operand = 32'd3;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_wb", wb_value, 32'd0);
        late = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) late++;
        end
        check("midrst_no_late_done", late, 0);
        run_op("divu_9_3", 2'b01, 5'd11, 32'd9, 32'd3, 0, 1'b0);

        // Randomized operations, biased towards corner operands.
        for (int i = 0; i < 40; i++) begin
            sel  = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 5);
            a    = $urandom;
            b    = $urandom;
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op("rand", sel, 5'($urandom_range(0, 31)), a, b, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
